rep3_serial_tx: RTL and testbench
=================================

// Module: rep3_serial_tx
// PURPOSE
//  Repetition-code serial transmitter: the encoding end of the majority-vote link.
//  - Accepts a DATA_W-bit word over a valid/ready handshake.
//  - Shifts the word out LSB-first on tx_bit, holding each bit for REP consecutive cycles.
//  - The downstream receiver recovers each bit by majority vote over its REP samples.
// PARAMETERS
//  DATA_W  8  payload width in bits, >=1
//  REP     3  cycles per bit (repetition factor); odd, >=1
// PORTS
//  clk       in   1       single clock, rising edge
//  rst_n     in   1       asynchronous reset, active-low
//  in_valid  in   1       in_data holds a word to send
//  in_data   in   DATA_W  payload word
//  in_ready  out  1       transmitter can capture a word this cycle
//  tx_bit    out  1       serial line, registered
//  tx_valid  out  1       high on every symbol cycle of a frame, registered
//  tx_start  out  1       one-cycle pulse on the first symbol of each frame, registered
//  busy      out  1       frame in progress (== tx_valid)
// BEHAVIOUR
//  - Reset: asynchronous on rst_n low.
//    - State IDLE; shift register, bit_cnt and rep_cnt cleared.
//    - tx_bit=0, tx_valid=0, tx_start=0, busy=0.
//    - No capture while rst_n is low.
//  - FSM states: IDLE, SEND.
//    - IDLE -> SEND on capture.
//    - SEND -> IDLE after the last symbol when no new capture occurs.
//    - SEND -> SEND on a back-to-back capture.
//  - in_ready (combinational) = (state==IDLE) | last-symbol cycle. The last-symbol cycle is
//    bit_cnt==NBITS-1 && rep_cnt==REP-1.
//  - Capture: in_valid && in_ready at a rising edge.
//    - Word latched.
//    - Next cycle: tx_valid=1, tx_start=1, tx_bit=in_data[0].
//    - Latency: 1 cycle from the capturing edge to the first symbol.
//  - Symbol timing:
//    - rep_cnt counts 0..REP-1 and wraps.
//    - On wrap, bit_cnt increments and tx_bit takes the next bit.
//    - NBITS = DATA_W, or DATA_W+1 with the parity option.
//    - Frame length is exactly NBITS*REP cycles. tx_start is high only on cycle 0 of a frame.
//  - Back-to-back: a capture in the last-symbol cycle starts the next frame on the following
//    cycle with no gap. tx_start pulses again and tx_valid stays high.
//  - Stall: with in_valid low at end of frame, next cycle tx_valid=0 and tx_bit=0, state IDLE.
//  - in_valid high while in_ready is low: ignored. The word is not captured and the active
//    frame is unaffected; the source must hold it.
//  - Reset mid-frame: frame aborted immediately, outputs as at reset. After release the first
//    capture starts a fresh frame.
//  - Counters are sized clog2(NBITS) and clog2(REP), minimum 1 bit. No wrap beyond terminal
//    counts.
// CONFIGURATION
//  REP3_TX_PARITY_EN
//  - Defined: one even-parity bit (XOR of all DATA_W payload bits) is appended after the MSB
//    and also repeated REP times.
//    - NBITS = DATA_W+1; frame length (DATA_W+1)*REP.
//  - Undefined: no parity logic; NBITS = DATA_W; frame length DATA_W*REP.
// TESTING
//  1. Reset, then in_data=8'hA5 with one-cycle in_valid:
//     - tx_bit = 111 000 111 000 000 111 000 111.
//     - 24 cycles with tx_valid=1; tx_start high only on cycle 0.
//     - Then tx_valid=0 and in_ready=1.
//  2. Parity on, 8'hA5: 24 cycles as in test 1, then 000 (parity=0), 27 cycles total.
//     Parity on, 8'h01: parity symbols 111.
//  3. 8'hFF then 8'h00, in_valid held high: second word captured in cycle 23.
//     - tx_bit = 24x1 then 24x0 with no gap.
//     - tx_start pulses at cycles 0 and 24.
//  4. in_valid=1 with in_data=8'h3C during cycles 2..10 of an active 8'hA5 frame:
//     - A5 sequence is unchanged.
//     - 8'h3C is captured only in cycle 23 (in_ready=1).
//  5. rst_n low at cycle 7 of a frame:
//     - tx_valid=0 and tx_bit=0 with no clock edge.
//     - After release, send 8'h81: full 24-cycle frame 111 000x6 111.
//  6. REP=1, DATA_W=4, 4'b1010:
//     - tx_bit = 0,1,0,1 over 4 cycles; tx_start on cycle 0 only.

Source files
------------

// File: rtl/rep3_serial_tx.sv
// rep3_serial_tx
//   Repetition-code serial transmitter. This is the encoding end of a
//   majority-vote link. It accepts a DATA_W-bit word over a valid/ready
//   handshake. It then shifts the word out LSB-first on tx_bit, holding each
//   bit for REP consecutive cycles so the receiver can majority-vote each bit.
//
// Parameters
//   DATA_W  payload width in bits (>=1)
//   REP     cycles per bit, odd (>=1)
//
// Ports
//   clk       in   single clock, rising edge
//   rst_n     in   asynchronous reset, active-low
//   in_valid  in   in_data holds a word to send
//   in_data   in   payload word [DATA_W-1:0]
//   in_ready  out  a word can be captured this cycle (combinational)
//   tx_bit    out  serial line, registered
//   tx_valid  out  high on every symbol cycle of a frame, registered
//   tx_start  out  one-cycle pulse on the first symbol of a frame, registered
//   busy      out  frame in progress (same as tx_valid)
//
// Configuration
//   REP3_TX_PARITY_EN  when defined, an even-parity bit (XOR of the payload)
//                      is appended after the MSB and repeated REP times,
//                      giving DATA_W+1 bits per frame.

module rep3_serial_tx #(
  parameter int DATA_W = 8,
  parameter int REP    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              tx_bit,
  output logic              tx_valid,
  output logic              tx_start,
  output logic              busy
);

`ifdef REP3_TX_PARITY_EN
  localparam int NBITS = DATA_W + 1;
`else
  localparam int NBITS = DATA_W;
`endif

  localparam int BIT_W = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int REP_W = (REP > 1) ? $clog2(REP) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NBITS - 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REP - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t            state;
  logic [NBITS-1:0]  shreg;
  logic [NBITS-1:0]  frame_word;
  logic [BIT_W-1:0]  bit_cnt;
  logic [REP_W-1:0]  rep_cnt;
  logic              last_sym;
  logic              capture;

  // Build the full frame from the incoming payload. With parity enabled the
  // even-parity bit rides above the MSB so it is shifted out last.
  always_comb begin
`ifdef REP3_TX_PARITY_EN
    frame_word = {^in_data, in_data};
`else
    frame_word = in_data;
`endif
  end

  // The last symbol cycle is the only moment inside a frame where a new word
  // may be accepted. This allows back-to-back frames with no idle gap.
  always_comb begin
    last_sym = (state == SEND) && (bit_cnt == BIT_LAST) && (rep_cnt == REP_LAST);
    in_ready = (state == IDLE) || last_sym;
    capture  = in_valid && in_ready;
  end

  assign busy = tx_valid;

  // Main sequencer. On capture, bit 0 goes straight onto tx_bit. The
  // remaining bits are parked in shreg, so that shreg[0] is always the next
  // bit to send when rep_cnt wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      rep_cnt  <= '0;
      tx_bit   <= 1'b0;
      tx_valid <= 1'b0;
      tx_start <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx_start <= 1'b0;
          if (capture) begin
            state    <= SEND;
            shreg    <= frame_word >> 1;
            bit_cnt  <= '0;
            rep_cnt  <= '0;
            tx_bit   <= frame_word[0];
            tx_valid <= 1'b1;
            tx_start <= 1'b1;
          end
        end

        SEND: begin
          tx_start <= 1'b0;
          if (last_sym) begin
            if (capture) begin
              shreg    <= frame_word >> 1;
              bit_cnt  <= '0;
              rep_cnt  <= '0;
              tx_bit   <= frame_word[0];
              tx_valid <= 1'b1;
              tx_start <= 1'b1;
            end else begin
              state    <= IDLE;
              shreg    <= '0;
              bit_cnt  <= '0;
              rep_cnt  <= '0;
              tx_bit   <= 1'b0;
              tx_valid <= 1'b0;
            end
          end else if (rep_cnt == REP_LAST) begin
            rep_cnt <= '0;
            bit_cnt <= bit_cnt + 1'b1;
            tx_bit  <= shreg[0];
            shreg   <= shreg >> 1;
          end else begin
            rep_cnt <= rep_cnt + 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          tx_bit   <= 1'b0;
          tx_valid <= 1'b0;
          tx_start <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rep3_serial_tx.sv
// tb_rep3_serial_tx
//   Self-checking bench for rep3_serial_tx. A queue of expected symbols is
//   built from each captured word. Each payload bit is repeated REP times,
//   and the parity bit is included when enabled. The DUT is compared against
//   that queue every cycle. A second small instance (DATA_W=4, REP=1) covers
//   the no-repetition corner.

module tb_rep3_serial_tx;

  localparam int DATA_W = 8;
  localparam int REP    = 3;
`ifdef REP3_TX_PARITY_EN
  localparam int NBITS  = DATA_W + 1;
  localparam int NB4    = 5;
`else
  localparam int NBITS  = DATA_W;
  localparam int NB4    = 4;
`endif
  localparam int FRAME  = NBITS * REP;

  typedef struct {
    logic b;
    logic s;
  } sym_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready, tx_bit, tx_valid, tx_start, busy;

  logic              in_valid4;
  logic [3:0]        in_data4;
  logic              in_ready4, tx_bit4, tx_valid4, tx_start4, busy4;

  int   errors = 0;
  int   checks = 0;
  sym_t exp_q[$];
  logic captured;

  always #5 clk = ~clk;

  rep3_serial_tx #(.DATA_W(DATA_W), .REP(REP)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .tx_bit(tx_bit), .tx_valid(tx_valid),
    .tx_start(tx_start), .busy(busy)
  );

  rep3_serial_tx #(.DATA_W(4), .REP(1)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_data(in_data4),
    .in_ready(in_ready4), .tx_bit(tx_bit4), .tx_valid(tx_valid4),
    .tx_start(tx_start4), .busy(busy4)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, observed, expected);
    end
  endtask

  // Reference model: a captured word becomes NBITS bits, each bit becomes
  // REP identical symbols, and the very first symbol carries the start flag.
  function automatic void pushFrame(input logic [DATA_W-1:0] w);
    sym_t sy;
    for (int i = 0; i < NBITS; i++) begin
      for (int r = 0; r < REP; r++) begin
        sy.b = (i < DATA_W) ? w[i] : logic'($countones(w) % 2);
        sy.s = (i == 0 && r == 0);
        exp_q.push_back(sy);
      end
    end
  endfunction

  // One clock cycle: drive inputs, check outputs on the falling edge, then
  // advance the model at the rising edge.
  task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d);
    logic model_ready;
    in_valid = v;
    in_data  = d;
    @(negedge clk);
    model_ready = (exp_q.size() <= 1);
    if (exp_q.size() > 0) begin
      checkOutput("tx_valid", 32'(tx_valid), 32'd1);
      checkOutput("tx_bit",   32'(tx_bit),   32'(exp_q[0].b));
      checkOutput("tx_start", 32'(tx_start), 32'(exp_q[0].s));
      checkOutput("busy",     32'(busy),     32'd1);
    end else begin
      checkOutput("idle_tx_valid", 32'(tx_valid), 32'd0);
      checkOutput("idle_tx_bit",   32'(tx_bit),   32'd0);
      checkOutput("idle_tx_start", 32'(tx_start), 32'd0);
      checkOutput("idle_busy",     32'(busy),     32'd0);
    end
    checkOutput("in_ready", 32'(in_ready), 32'(model_ready));
    @(posedge clk);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    captured = v && model_ready;
    if (captured) pushFrame(d);
    #1;
  endtask

  initial begin
    int   n;
    logic pend;
    logic [DATA_W-1:0] word;
    logic [3:0] w4;
    logic exp4;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_valid4 = 1'b0;
    in_data4  = '0;
    captured  = 1'b0;

    // Reset state
    #2;
    checkOutput("rst_tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("rst_tx_bit",   32'(tx_bit),   32'd0);
    checkOutput("rst_tx_start", 32'(tx_start), 32'd0);
    checkOutput("rst_busy",     32'(busy),     32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // REP=1, DATA_W=4 corner: 4'b1010 sent one symbol per cycle
    w4 = 4'b1010;
    in_valid4 = 1'b1;
    in_data4  = w4;
    @(posedge clk);
    #1 in_valid4 = 1'b0;
    for (int k = 0; k < NB4; k++) begin
      @(negedge clk);
      exp4 = (k < 4) ? w4[k] : logic'($countones(w4) % 2);
      checkOutput("r1_tx_valid", 32'(tx_valid4), 32'd1);
      checkOutput("r1_tx_bit",   32'(tx_bit4),   32'(exp4));
      checkOutput("r1_tx_start", 32'(tx_start4), 32'(k == 0));
    end
    @(negedge clk);
    checkOutput("r1_end_valid", 32'(tx_valid4), 32'd0);
    checkOutput("r1_end_ready", 32'(in_ready4), 32'd1);
    @(posedge clk);
    #1;

    // Single A5 frame, then idle
    applyStimulus(1'b1, 8'hA5);
    for (int k = 0; k < FRAME + 3; k++) applyStimulus(1'b0, 8'h00);

    // Parity-relevant word 01
    applyStimulus(1'b1, 8'h01);
    for (int k = 0; k < FRAME + 2; k++) applyStimulus(1'b0, 8'h00);

    // Back-to-back FF then 00 with in_valid held
    applyStimulus(1'b1, 8'hFF);
    n = 0;
    captured = 1'b0;
    while (!captured && n < 4 * FRAME) begin
      applyStimulus(1'b1, 8'h00);
      n++;
    end
    checkOutput("b2b_capture_cycle", 32'(n), 32'(FRAME));
    for (int k = 0; k < FRAME + 2; k++) applyStimulus(1'b0, 8'h00);

    // 3C offered while A5 is in flight; accepted only at the last symbol
    applyStimulus(1'b1, 8'hA5);
    n = 0;
    for (int k = 1; k <= 11; k++) applyStimulus(k >= 3, 8'h3C);
    captured = 1'b0;
    while (!captured && n < 4 * FRAME) begin
      applyStimulus(1'b1, 8'h3C);
      n++;
    end
    checkOutput("hold_capture_cycle", 32'(n + 11), 32'(FRAME));
    for (int k = 0; k < FRAME + 2; k++) applyStimulus(1'b0, 8'h00);

    // Reset at frame cycle 7: outputs clear without any clock edge
    applyStimulus(1'b1, 8'hA5);
    for (int k = 0; k < 7; k++) applyStimulus(1'b0, 8'h00);
    #1 rst_n = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    #1;
    checkOutput("arst_tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("arst_tx_bit",   32'(tx_bit),   32'd0);
    checkOutput("arst_busy",     32'(busy),     32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    in_valid = 1'b0;
    applyStimulus(1'b0, 8'h00);
    applyStimulus(1'b1, 8'h81);
    for (int k = 0; k < FRAME + 2; k++) applyStimulus(1'b0, 8'h00);

    // Randomised traffic: the source holds a word until it is taken
    pend = 1'b0;
    word = '0;
    for (int k = 0; k < 800; k++) begin
      if (!pend) begin
        word = DATA_W'($urandom);
        pend = ($urandom_range(0, 2) != 0);
      end
      applyStimulus(pend && ($urandom_range(0, 3) != 0), word);
      if (captured) pend = 1'b0;
    end
    for (int k = 0; k < FRAME + 2; k++) applyStimulus(1'b0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
